timer_ctrl_front: RTL and testbench

Front-end control stage that drives the 30-second BCD down-counter block. It divides the board clock into the 1 Hz count clock and turns the noisy start/pause pushbutton into a clean enable level. It also forces the count to pause when the counter reports expiry. It sits between the board pins (clock, pushbutton) and the counter's clk/enable inputs.

---
 rtl/timer_ctrl_front_pkg.sv | 14 +
 rtl/timer_ctrl_front_pb_debounce.sv | 51 +++++
 rtl/timer_ctrl_front.sv | 87 ++++++++
 tb/tb_timer_ctrl_front.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/timer_ctrl_front_pkg.sv
// Shared constants and state encoding for the timer front-end control stage.
// Default divisor values assume a 40 MHz board clock.
package timer_ctrl_front_pkg;

   typedef enum logic {
      StPause = 1'b0,
      StRun   = 1'b1
   } state_e;

   localparam int unsigned HALF_1HZ_DEF   = 20000000;
   localparam int unsigned SAMPLE_DIV_DEF = 400000;
   localparam int unsigned DB_LEN_DEF     = 4;

endpackage

// File: rtl/timer_ctrl_front_pb_debounce.sv
// Pushbutton conditioning: two-flop synchroniser, sampled shift-register debounce
// and a one-cycle press pulse on each debounced rising edge.
module timer_ctrl_front_pb_debounce
   import timer_ctrl_front_pkg::*;
#(
   parameter int unsigned DB_LEN = DB_LEN_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick_smp,
   input  logic pb_in,
   output logic pb_level,
   output logic press
);

   logic              r_pb_s1;
   logic              r_pb_s2;
   logic [DB_LEN-1:0] r_sh;
   logic [DB_LEN-1:0] w_sh_next;
   logic              r_level;
   logic              r_pb_d;

   assign w_sh_next = (r_sh << 1) | DB_LEN'(r_pb_s2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pb_s1 <= 1'b0;
         r_pb_s2 <= 1'b0;
         r_sh    <= '0;
         r_level <= 1'b0;
         r_pb_d  <= 1'b0;
      end else begin
         r_pb_s1 <= pb_in;
         r_pb_s2 <= r_pb_s1;
         if (tick_smp) begin
            r_sh <= w_sh_next;
         end
         // Mixed sample history leaves the level untouched.
         if (&r_sh) begin
            r_level <= 1'b1;
         end else if (~|r_sh) begin
            r_level <= 1'b0;
         end
         r_pb_d <= r_level;
      end
   end

   assign pb_level = r_level;
   assign press    = r_level & ~r_pb_d;

endmodule

// File: rtl/timer_ctrl_front.sv
// Front-end for the 30-second BCD down-counter: 1 Hz clock divider, debounce
// sample tick and the RUN/PAUSE enable state machine.
module timer_ctrl_front
   import timer_ctrl_front_pkg::*;
#(
   parameter int unsigned HALF_1HZ   = HALF_1HZ_DEF,
   parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEF,
   parameter int unsigned DB_LEN     = DB_LEN_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pb_in,
   input  logic expired,
   output logic clk_1hz,
   output logic enable,
   output logic pb_level
);

   localparam int unsigned W1HZ = (HALF_1HZ > 1) ? $clog2(HALF_1HZ) : 1;
   localparam int unsigned WSMP = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [W1HZ-1:0] LAST_1HZ = W1HZ'(HALF_1HZ - 1);
   localparam logic [WSMP-1:0] LAST_SMP = WSMP'(SAMPLE_DIV - 1);

   logic [W1HZ-1:0] r_cnt_1hz;
   logic            r_clk_1hz;
   logic [WSMP-1:0] r_cnt_smp;
   logic            w_tick_smp;
   logic            w_press;
   state_e          r_state;
   state_e          w_state_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt_1hz <= '0;
         r_clk_1hz <= 1'b0;
      end else if (r_cnt_1hz == LAST_1HZ) begin
         r_cnt_1hz <= '0;
         r_clk_1hz <= ~r_clk_1hz;
      end else begin
         r_cnt_1hz <= r_cnt_1hz + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt_smp <= '0;
      end else if (w_tick_smp) begin
         r_cnt_smp <= '0;
      end else begin
         r_cnt_smp <= r_cnt_smp + 1'b1;
      end
   end

   assign w_tick_smp = (r_cnt_smp == LAST_SMP);

   timer_ctrl_front_pb_debounce #(
      .DB_LEN (DB_LEN)
   ) u_pb_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_smp (w_tick_smp),
      .pb_in    (pb_in),
      .pb_level (pb_level),
      .press    (w_press)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StPause;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Expiry dominates: a press coinciding with expiry never leaves RUN active.
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StPause: if (w_press && !expired) w_state_d = StRun;
         StRun:   if (expired || w_press)  w_state_d = StPause;
      endcase
   end

   assign clk_1hz = r_clk_1hz;
   assign enable  = (r_state == StRun);

endmodule

// File: tb/tb_timer_ctrl_front.sv
// Directed bench for timer_ctrl_front with HALF_1HZ=5, SAMPLE_DIV=4, DB_LEN=4.
module tb_timer_ctrl_front;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic pb_in = 1'b0;
   logic expired = 1'b0;
   logic clk_1hz;
   logic enable;
   logic pb_level;

   int n_cmp = 0;
   int n_fail = 0;
   int edges = 0;

   timer_ctrl_front #(
      .HALF_1HZ   (5),
      .SAMPLE_DIV (4),
      .DB_LEN     (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pb_in    (pb_in),
      .expired  (expired),
      .clk_1hz  (clk_1hz),
      .enable   (enable),
      .pb_level (pb_level)
   );

   always #5 clk = ~clk;

   // Clock edges since reset release; edges % 5 is the divider phase.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edges <= 0;
      else        edges <= edges + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Wait for pb_level to reach want; latency from the input change must be 16..19 clk.
   task automatic wait_level(input logic want, input string tag);
      int lat = 0;
      while (pb_level !== want && lat < 30) begin
         tick();
         lat++;
      end
      n_cmp++;
      assert (lat >= 16 && lat <= 19) else begin
         n_fail++;
         $error("FAIL %s: latency %0d expected 16..19", tag, lat);
      end
   endtask

   // Clean press and release; enable goes en_before -> en_after one clk after pb_level rises.
   task automatic press(input logic en_before, input logic en_after, input logic exp_rise,
                        input string tag);
      pb_in = 1'b1;
      wait_level(1'b1, {tag, "_rise_lat"});
      if (exp_rise) expired = 1'b1;
      chk({tag, "_en_pre"}, enable, en_before);
      tick();
      chk({tag, "_en_post"}, enable, en_after);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk({tag, "_en_hold"}, enable, en_after);
      end
      pb_in = 1'b0;
      wait_level(1'b0, {tag, "_fall_lat"});
      for (int i = 0; i < 3; i++) begin
         tick();
         chk({tag, "_en_rel"}, enable, en_after);
      end
   endtask

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) tick();
      chk("rst_clk_1hz", clk_1hz, 1'b0);
      chk("rst_enable", enable, 1'b0);
      chk("rst_pb_level", pb_level, 1'b0);

      // Divider: rises at edge 5, falls at edge 10, period 10.
      @(negedge clk) rst_n = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         tick();
         chk("div_clk_1hz", clk_1hz, logic'((k / 5) % 2));
         chk("div_enable", enable, 1'b0);
      end

      // Short bounce: at most two ones reach the sample history.
      pb_in = 1'b1;
      repeat (6) tick();
      pb_in = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         chk("bounce_pb_level", pb_level, 1'b0);
         chk("bounce_enable", enable, 1'b0);
      end

      press(1'b0, 1'b1, 1'b0, "press1");
      press(1'b1, 1'b0, 1'b0, "press2");
      press(1'b0, 1'b1, 1'b0, "press3");

      // Expiry forces PAUSE; presses are ignored while expired.
      expired = 1'b1;
      tick();
      chk("exp_pause", enable, 1'b0);
      press(1'b0, 1'b0, 1'b0, "press_exp");
      expired = 1'b0;
      press(1'b0, 1'b1, 1'b0, "press_unexp");

      // Press and expiry rising together from RUN.
      press(1'b1, 1'b0, 1'b1, "press_sim");
      expired = 1'b0;
      tick();
      chk("sim_after_clear", enable, 1'b0);

      // Get to RUN with the button held, then reset at divider phase 3 while clk_1hz is high.
      pb_in = 1'b1;
      wait_level(1'b1, "pre_rst_lat");
      tick();
      chk("pre_rst_enable", enable, 1'b1);
      for (int i = 0; i < 10 && (edges % 10) != 8; i++) tick();
      chk("pre_rst_clk_1hz", clk_1hz, 1'b1);
      chk("pre_rst_pb_level", pb_level, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_clk_1hz", clk_1hz, 1'b0);
      chk("mid_rst_enable", enable, 1'b0);
      chk("mid_rst_pb_level", pb_level, 1'b0);
      pb_in = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk("rerun_clk_1hz", clk_1hz, logic'((k / 5) % 2));
         chk("rerun_enable", enable, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
